disp_arbiter: RTL and testbench

DISP_ARBITER -- requirements
Module: disp_arbiter

---
 rtl/disp_arbiter.sv | 131 +++++++++++++
 tb/tb_disp_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/disp_arbiter.sv
// disp_arbiter
//   Two-way arbiter for a shared seven-segment display. Requester 0 (core) and
//   requester 1 (debug/status) compete for the display. A granted requester
//   owns it for at least DWELL cycles. After that it can be preempted by the
//   other requester. Ties from IDLE are broken round-robin, and requester 0
//   wins the first tie after reset. All outputs are registered.
//
// Ports
//   clk       : system clock
//   rst       : asynchronous, active-high reset
//   req0      : requester 0 wants the display
//   data0     : requester 0 display value
//   req1      : requester 1 wants the display
//   data1     : requester 1 display value
//   gnt0      : requester 0 currently owns the display
//   gnt1      : requester 1 currently owns the display
//   data_seg  : value driven to the seven-segment driver
//   owner     : index of the last granted requester
module disp_arbiter #(
  parameter int unsigned DWELL = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [31:0] data0,
  input  logic        req1,
  input  logic [31:0] data1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [31:0] data_seg,
  output logic        owner
);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  localparam logic [31:0] DWELL_MAX = 32'(DWELL - 1);

  state_t      state_q, state_d;
  logic        rr_q, rr_d;
  logic        owner_d, gnt0_d, gnt1_d;
  logic [31:0] data_d;
  logic [31:0] cnt_q, cnt_d;

  logic        grant_en;
  logic        grant_idx;
  logic        own_req, oth_req;

  // Dwell counter increment that sticks at DWELL-1. An owner that is never
  // challenged therefore stays preemptable forever without the counter wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    if (v >= DWELL_MAX) return DWELL_MAX;
    else                return v + 32'd1;
  endfunction

  assign own_req = owner ? req1 : req0;
  assign oth_req = owner ? req0 : req1;

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    owner_d   = owner;
    gnt0_d    = gnt0;
    gnt1_d    = gnt1;
    data_d    = data_seg;
    cnt_d     = cnt_q;
    grant_en  = 1'b0;
    grant_idx = owner;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          grant_en  = 1'b1;
          // On a tie, take the requester that was not granted last.
          grant_idx = (req0 && req1) ? ~rr_q : req1;
        end
      end
      OWN: begin
        // Hand over when the dwell has expired. Also hand over when the owner
        // leaves while the other side is waiting, so that no idle cycle is
        // inserted between the two grants.
        if (oth_req && (!own_req || cnt_q == DWELL_MAX)) begin
          grant_en  = 1'b1;
          grant_idx = ~owner;
        end else if (!own_req) begin
          // data_seg keeps the last value shown.
          state_d = IDLE;
          gnt0_d  = 1'b0;
          gnt1_d  = 1'b0;
        end else begin
          data_d = owner ? data1 : data0;
          cnt_d  = sat_inc(cnt_q);
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant_en) begin
      state_d = OWN;
      owner_d = grant_idx;
      rr_d    = grant_idx;
      gnt0_d  = ~grant_idx;
      gnt1_d  = grant_idx;
      data_d  = grant_idx ? data1 : data0;
      cnt_d   = 32'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_q     <= 1'b1;
      owner    <= 1'b0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      data_seg <= 32'h0;
      cnt_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      owner    <= owner_d;
      gnt0     <= gnt0_d;
      gnt1     <= gnt1_d;
      data_seg <= data_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_disp_arbiter.sv
// tb_disp_arbiter
//   Directed bench for disp_arbiter with DWELL=4. Inputs change 1 time unit
//   after each rising edge. Outputs are checked at that same point, which is
//   1 time unit after the edge. The grant invariants are checked on every
//   falling edge.
module tb_disp_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [31:0] data0, data1;
  logic        gnt0, gnt1, owner;
  logic [31:0] data_seg;

  int checks = 0;
  int errors = 0;

  disp_arbiter #(.DWELL(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .data0(data0),
    .req1(req1), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1),
    .data_seg(data_seg), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // The two grants are mutually exclusive, and the grant is present exactly
  // when the arbiter is in OWN (state encoding: OWN = 1).
  always @(negedge clk) begin
    checks++;
    assert (!(gnt0 && gnt1) && ((gnt0 | gnt1) === logic'(dut.state_q))) else begin
      errors++;
      $error("FAIL gnt_excl observed gnt0=%0b gnt1=%0b state=%0b expected onehot-or-zero matching state",
             gnt0, gnt1, logic'(dut.state_q));
    end
  end

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = 32'h0; data1 = 32'h0;
    tick();
    chk("rst_gnt0", 32'(gnt0), 32'd0);
    chk("rst_gnt1", 32'(gnt1), 32'd0);
    chk("rst_data", data_seg, 32'h0);
    chk("rst_owner", 32'(owner), 32'd0);
    rst = 1'b0;
    tick();

    // Single requester 0: one-cycle grant latency.
    req0 = 1'b1; data0 = 32'h0000_1234;
    tick();
    chk("s1_gnt0", 32'(gnt0), 32'd1);
    chk("s1_gnt1", 32'(gnt1), 32'd0);
    chk("s1_data", data_seg, 32'h0000_1234);
    chk("s1_owner", 32'(owner), 32'd0);
    tick();                       // dwell count now 1
    chk("s3_hold", 32'(gnt0), 32'd1);
    // Owner drops at count 1. data_seg must not pick up the new data0.
    req0 = 1'b0; data0 = 32'h0000_FFFF;
    tick();
    chk("s3_gnt0", 32'(gnt0), 32'd0);
    chk("s3_idle", 32'(dut.state_q), 32'd0);
    chk("s3_data", data_seg, 32'h0000_1234);
    tick();
    chk("s3_data_idle", data_seg, 32'h0000_1234);

    // Tie from IDLE after reset: gnt0 for exactly 4 cycles, then gnt1.
    rst = 1'b1;
    #2 rst = 1'b0;
    req0 = 1'b1; data0 = 32'h0000_00A0;
    req1 = 1'b1; data1 = 32'h0000_00B1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("s2_gnt0_c%0d", i), 32'(gnt0), 32'd1);
      chk($sformatf("s2_gnt1_c%0d", i), 32'(gnt1), 32'd0);
    end
    tick();
    chk("s2_sw_gnt0", 32'(gnt0), 32'd0);
    chk("s2_sw_gnt1", 32'(gnt1), 32'd1);
    chk("s2_sw_data", data_seg, 32'h0000_00B1);
    chk("s2_sw_owner", 32'(owner), 32'd1);

    // Owner 1 reaches count 3 and drops req1 while req0 waits. The grant must
    // switch directly to requester 0, with no idle cycle.
    tick(); tick(); tick();
    chk("s21_pre_gnt1", 32'(gnt1), 32'd1);
    req1 = 1'b0; data0 = 32'h0000_00C2;
    tick();
    chk("s21_gnt0", 32'(gnt0), 32'd1);
    chk("s21_gnt1", 32'(gnt1), 32'd0);
    chk("s21_data", data_seg, 32'h0000_00C2);
    chk("s21_owner", 32'(owner), 32'd0);

    // Let it go idle, then requester 1 alone for 20 cycles with live data.
    req0 = 1'b0;
    tick();
    chk("s4_idle_gnt0", 32'(gnt0), 32'd0);
    req1 = 1'b1; data1 = 32'd100;
    tick();
    chk("s4_gnt1", 32'(gnt1), 32'd1);
    chk("s4_data0", data_seg, 32'd100);
    for (int i = 1; i < 20; i++) begin
      data1 = 32'd100 + 32'(i);
      tick();
      chk($sformatf("s4_gnt1_c%0d", i), 32'(gnt1), 32'd1);
      chk($sformatf("s4_data_c%0d", i), data_seg, 32'd100 + 32'(i));
    end

    // Asynchronous reset between edges while gnt1 is high.
    #2 rst = 1'b1;
    #1;
    chk("s5_gnt1", 32'(gnt1), 32'd0);
    chk("s5_data", data_seg, 32'h0);
    chk("s5_owner", 32'(owner), 32'd0);
    req0 = 1'b1; req1 = 1'b1; data0 = 32'h0000_0D00; data1 = 32'h0000_0D11;
    #1 rst = 1'b0;
    tick();
    chk("s5_rel_gnt0", 32'(gnt0), 32'd1);
    chk("s5_rel_gnt1", 32'(gnt1), 32'd0);
    chk("s5_rel_data", data_seg, 32'h0000_0D00);

    req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
